mult_sweep_eval: RTL and testbench
==================================

MULT_SWEEP_EVAL -- requirements
Module: mult_sweep_eval

Interface
REQ-001 SHALL have parameter: SETTLE_CYC, default 1, number of cycles operands are held before y_in is sampled (range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a full sweep.
REQ-005 SHALL have port: a  output  4  operand A driven to the external multiplier under test.
REQ-006 SHALL have port: b  output  4  operand B driven to the external multiplier under test.
REQ-007 SHALL have port: y_in  input  8  product returned by the multiplier under test (combinational path from a/b).
REQ-008 SHALL have port: busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port: done  output  1  high from sweep completion until the next start or reset.
REQ-010 SHALL have port: correct_cnt  output  9  number of vectors with y_in equal to the exact product (0..256).
REQ-011 SHALL have port: err_sum  output  16  sum of error distances |y_in - a*b| over all vectors.
REQ-012 SHALL have port: max_ed  output  8  largest single error distance seen.

Function
REQ-013 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-014 SHALL go from IDLE or DONE to SETTLE on start=1 and clear index, settle counter and all three accumulators in that same cycle.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL drive a=index[7:4], b=index[3:0] from an 8-bit vector index starting at 0.
REQ-017 SHALL hold a/b stable for SETTLE_CYC cycles in SETTLE, then spend exactly one cycle in SAMPLE.
REQ-018 SHALL, in SAMPLE, compute exact = a*b (8-bit unsigned) and ed = |y_in - exact| (8-bit unsigned), then register the updates.
REQ-019 SHALL, on the SAMPLE edge, increment correct_cnt when ed=0, add ed to err_sum, and set max_ed=ed when ed>max_ed.
REQ-020 SHALL, after SAMPLE, increment the index and return to SETTLE when index<255; at index=255 it SHALL enter DONE without wrapping the index.
REQ-021 SHALL take exactly 256*(SETTLE_CYC+1) cycles from the start edge to done=1.
REQ-022 SHALL assert busy in SETTLE and SAMPLE, and done only in DONE.
REQ-023 SHALL hold accumulators stable in DONE and IDLE; a and b SHALL hold their last values in both states.
REQ-024 SHALL never overflow err_sum or correct_cnt (worst case 65280 and 256).

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-sweep, immediately force: state IDLE, index 0, a=0, b=0, busy=0, done=0, correct_cnt=0, err_sum=0, max_ed=0.
REQ-026 SHALL require a new start after rst_n deasserts; the sweep SHALL NOT resume.

Structure
REQ-027 SHALL place the state encoding, the operand width (4), the product width (8) and the accumulator widths (9, 16) in shared package mult_eval_pkg.
REQ-028 SHALL use one combinational sub-module, mult_ref_4x4, for the exact product and error distance (inputs a, b, y; outputs exact, ed).
REQ-029 SHALL keep the multiplier under test outside the block and connect it only through a, b and y_in.

Verification
REQ-030 SHALL cover: exact multiplier attached, SETTLE_CYC=1, start -> done after 512 cycles, correct_cnt=256, err_sum=0, max_ed=0.
REQ-031 SHALL cover: y_in tied to 0 -> correct_cnt=31, err_sum=14400, max_ed=225.
REQ-032 SHALL cover: y_in tied to 8'hFF -> correct_cnt=0, err_sum=50880, max_ed=255.
REQ-033 SHALL cover: rst_n pulsed low during vector 100 -> all outputs 0 within the reset; a later start gives the full 512-cycle sweep with the REQ-030 results.
REQ-034 SHALL cover: start pulsed at cycle 50 of a sweep -> no effect, done still at cycle 512; start while done=1 -> accumulators clear and a new sweep begins.
REQ-035 SHALL cover: SETTLE_CYC=3 with exact multiplier -> done after 1024 cycles, and a/b unchanged across each 4-cycle vector window.

Source files
------------

// File: rtl/mult_eval_pkg.sv
// mult_eval_pkg: shared widths and FSM encoding for the 4x4 multiplier sweep evaluator
package mult_eval_pkg;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int IDX_W  = 8;
  localparam int CNT_W  = 9;
  localparam int SUM_W  = 16;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/mult_ref_4x4.sv
// mult_ref_4x4: exact 4x4 product and unsigned distance to the observed product
module mult_ref_4x4
  import mult_eval_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] y,
  output logic [PROD_W-1:0] exact,
  output logic [PROD_W-1:0] ed
);
  assign exact = PROD_W'(a) * PROD_W'(b);
  assign ed    = (y >= exact) ? y - exact : exact - y;
endmodule

// File: rtl/mult_sweep_eval.sv
// mult_sweep_eval: drives all 256 operand pairs to an external multiplier and
// accumulates exact-match count, total and maximum error distance
module mult_sweep_eval
  import mult_eval_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [OP_W-1:0]   a,
  output logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] y_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  correct_cnt,
  output logic [SUM_W-1:0]  err_sum,
  output logic [PROD_W-1:0] max_ed
);
  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_settle;
  logic [CNT_W-1:0]   r_correct;
  logic [SUM_W-1:0]   r_err_sum;
  logic [PROD_W-1:0]  r_max_ed;
  logic [PROD_W-1:0]  w_exact, w_ed;
  logic               w_start_ok, w_settle_end, w_last;

  assign w_start_ok   = start && (r_state == IDLE || r_state == DONE);
  assign w_settle_end = r_settle == 4'(SETTLE_CYC - 1);
  assign w_last       = r_idx == '1;

  mult_ref_4x4 u_ref (
    .a    (a),
    .b    (b),
    .y    (y_in),
    .exact(w_exact),
    .ed   (w_ed)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = start ? SETTLE : r_state;
      SETTLE:     w_next = w_settle_end ? SAMPLE : SETTLE;
      SAMPLE:     w_next = w_last ? DONE : SETTLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_settle  <= '0;
      r_correct <= '0;
      r_err_sum <= '0;
      r_max_ed  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_idx     <= '0;
        r_settle  <= '0;
        r_correct <= '0;
        r_err_sum <= '0;
        r_max_ed  <= '0;
      end else if (r_state == SETTLE) begin
        r_settle <= w_settle_end ? '0 : r_settle + 4'd1;
      end else if (r_state == SAMPLE) begin
        r_correct <= r_correct + CNT_W'(w_ed == '0);
        r_err_sum <= r_err_sum + SUM_W'(w_ed);
        r_max_ed  <= (w_ed > r_max_ed) ? w_ed : r_max_ed;
        // index parks at 255 so a/b keep the final vector in DONE
        r_idx     <= w_last ? r_idx : r_idx + 8'd1;
      end
    end
  end

  assign a           = r_idx[7:4];
  assign b           = r_idx[3:0];
  assign busy        = r_state == SETTLE || r_state == SAMPLE;
  assign done        = r_state == DONE;
  assign correct_cnt = r_correct;
  assign err_sum     = r_err_sum;
  assign max_ed      = r_max_ed;
endmodule

// File: tb/tb_mult_sweep_eval.sv
// tb_mult_sweep_eval: sweeps two evaluators (SETTLE_CYC 1 and 3) against modelled multipliers
module tb_mult_sweep_eval;
  logic clk = 0, rst_n = 0, start0 = 0, start1 = 0;
  logic [3:0] a0, b0, a1, b1;
  logic [7:0] y0, y1, me0, me1;
  logic busy0, done0, busy1, done1;
  logic [8:0] cc0, cc1;
  logic [15:0] es0, es1;
  int mode = 0;
  logic [7:0] tbl [256];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  // multiplier under test: 0 exact, 1 stuck-zero, 2 stuck-FF, 3 random lookup table
  always_comb begin
    y0 = mode == 0 ? {4'b0, a0} * {4'b0, b0} : mode == 1 ? 8'h00 : mode == 2 ? 8'hFF : tbl[{a0, b0}];
    y1 = mode == 0 ? {4'b0, a1} * {4'b0, b1} : mode == 1 ? 8'h00 : mode == 2 ? 8'hFF : tbl[{a1, b1}];
  end

  mult_sweep_eval #(.SETTLE_CYC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .y_in(y0),
    .busy(busy0), .done(done0), .correct_cnt(cc0), .err_sum(es0), .max_ed(me0)
  );

  mult_sweep_eval #(.SETTLE_CYC(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .y_in(y1),
    .busy(busy1), .done(done1), .correct_cnt(cc1), .err_sum(es1), .max_ed(me1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_model(input int m, output logic [32:0] exp_v);
    int cc = 0, es = 0, me = 0;
    for (int i = 0; i < 256; i++) begin
      int p = (i / 16) * (i % 16);
      int y = m == 0 ? p : m == 1 ? 0 : m == 2 ? 255 : int'(tbl[i]);
      int ed = y > p ? y - p : p - y;
      if (ed == 0) cc++;
      es += ed;
      if (ed > me) me = ed;
    end
    exp_v = {9'(cc), 16'(es), 8'(me)};
  endtask

  // start a sweep, count cycles to done and tally index/busy deviations per cycle
  task automatic run(input int which, input int pulse_at, output int n, output int bad);
    int s = which == 0 ? 1 : 3;
    if (which == 0) start0 = 1; else start1 = 1;
    tick();
    start0 = 0;
    start1 = 0;
    n = 0;
    bad = 0;
    while ((which == 0 ? done0 : done1) == 1'b0 && n < 3000) begin
      if ((which == 0 ? {a0, b0} : {a1, b1}) != 8'(n / (s + 1))) bad++;
      if ((which == 0 ? busy0 : busy1) != 1'b1) bad++;
      if (which == 0) start0 = (n == pulse_at); else start1 = (n == pulse_at);
      tick();
      n++;
    end
    start0 = 0;
    start1 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    tests++;
    if ({a0, b0, busy0, done0, cc0, es0, me0} !== '0) begin
      fails++;
      $display("FAIL reset_dut0: got a=%0d b=%0d busy=%b done=%b cc=%0d es=%0d me=%0d exp all 0", a0, b0, busy0, done0, cc0, es0, me0);
    end
    tests++;
    if ({a1, b1, busy1, done1, cc1, es1, me1} !== '0) begin
      fails++;
      $display("FAIL reset_dut1: got a=%0d b=%0d busy=%b done=%b cc=%0d es=%0d me=%0d exp all 0", a1, b1, busy1, done1, cc1, es1, me1);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_sweep(input string name, input int m, input int pulse_at);
    int n, bad;
    logic [32:0] exp_v;
    mode = m;
    ref_model(m, exp_v);
    run(0, pulse_at, n, bad);
    tests++;
    if (n != 512 || bad != 0) begin
      fails++;
      $display("FAIL %s_timing: got cycles=%0d deviations=%0d exp cycles=512 deviations=0", name, n, bad);
    end
    tests++;
    if ({cc0, es0, me0} !== exp_v) begin
      fails++;
      $display("FAIL %s_result: got cc=%0d es=%0d me=%0d exp cc=%0d es=%0d me=%0d", name, cc0, es0, me0, exp_v[32:24], exp_v[23:8], exp_v[7:0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++)
        tbl[i] = $urandom_range(0, 2) == 0 ? 8'((i / 16) * (i % 16)) : 8'($urandom);
      test_sweep("random", 3, -1);
    end
  endtask

  task automatic test_start_in_done();
    int n = 0;
    test_sweep("prefill_ff", 2, -1);
    tests++;
    if ({a0, b0, done0} !== {4'd15, 4'd15, 1'b1}) begin
      fails++;
      $display("FAIL hold_in_done: got a=%0d b=%0d done=%b exp a=15 b=15 done=1", a0, b0, done0);
    end
    mode = 0;
    start0 = 1;
    tick();
    start0 = 0;
    tests++;
    if ({busy0, done0, cc0, es0, me0} !== {1'b1, 1'b0, 33'd0}) begin
      fails++;
      $display("FAIL restart_clear: got busy=%b done=%b cc=%0d es=%0d me=%0d exp busy=1 done=0 zeros", busy0, done0, cc0, es0, me0);
    end
    while (!done0 && n < 3000) begin
      tick();
      n++;
    end
    tests++;
    if (n != 512 || {cc0, es0, me0} !== {9'd256, 24'd0}) begin
      fails++;
      $display("FAIL restart_sweep: got cycles=%0d cc=%0d es=%0d me=%0d exp 512 256 0 0", n, cc0, es0, me0);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2;
    start0 = 1;
    tick();
    start0 = 0;
    repeat (200) tick();
    tests++;
    if ({a0, b0, busy0} !== {8'd100, 1'b1}) begin
      fails++;
      $display("FAIL mid_vector: got ab=%0d busy=%b exp ab=100 busy=1", {a0, b0}, busy0);
    end
    rst_n = 0;
    #1;
    tests++;
    if ({a0, b0, busy0, done0, cc0, es0, me0} !== '0) begin
      fails++;
      $display("FAIL mid_reset: got a=%0d b=%0d busy=%b done=%b cc=%0d es=%0d me=%0d exp all 0", a0, b0, busy0, done0, cc0, es0, me0);
    end
    repeat (2) tick();
    rst_n = 1;
    repeat (5) tick();
    tests++;
    if ({a0, b0, busy0, done0} !== '0) begin
      fails++;
      $display("FAIL no_resume: got a=%0d b=%0d busy=%b done=%b exp idle zeros", a0, b0, busy0, done0);
    end
    test_sweep("after_reset", 0, -1);
  endtask

  task automatic test_settle3();
    int n, bad;
    mode = 0;
    run(1, -1, n, bad);
    tests++;
    if (n != 1024 || bad != 0) begin
      fails++;
      $display("FAIL settle3_timing: got cycles=%0d deviations=%0d exp cycles=1024 deviations=0", n, bad);
    end
    tests++;
    if ({cc1, es1, me1} !== {9'd256, 24'd0}) begin
      fails++;
      $display("FAIL settle3_result: got cc=%0d es=%0d me=%0d exp 256 0 0", cc1, es1, me1);
    end
  endtask

  initial begin
    test_reset();
    test_sweep("exact", 0, -1);
    test_sweep("zero", 1, -1);
    test_sweep("ones", 2, -1);
    test_random();
    test_sweep("start_ignored", 0, 50);
    test_start_in_done();
    test_reset_mid();
    test_settle3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
